// File: rtl/time_manage_multi_if.sv
// Trigger, configuration and status bundle for the acquisition timing sequencer.
interface time_manage_multi_if #(
  parameter int CNT_W  = 24,
  parameter int CH_NUM = 4,
  parameter int FCNT_W = 16
);
  logic              trig_gpio_i;
  logic              trig_vio_i;
  logic              trig_sel_i;
  logic              cfg_mode_i;
  logic [CNT_W-1:0]  cfg_reset_len_i;
  logic [CNT_W-1:0]  cfg_frame_len_i;
  logic [CNT_W-1:0]  cfg_acq_period_i;
  logic [FCNT_W-1:0] cfg_frame_cnt_i;
  logic              reset_win_o;
  logic              frame_pulse_o;
  logic [CH_NUM-1:0] acq_start_o;
  logic              busy_o;
  logic              done_pulse_o;
  logic [FCNT_W-1:0] frame_idx_o;

  modport master (
    output trig_gpio_i, trig_vio_i, trig_sel_i, cfg_mode_i,
           cfg_reset_len_i, cfg_frame_len_i, cfg_acq_period_i, cfg_frame_cnt_i,
    input  reset_win_o, frame_pulse_o, acq_start_o, busy_o, done_pulse_o, frame_idx_o
  );

  modport slave (
    input  trig_gpio_i, trig_vio_i, trig_sel_i, cfg_mode_i,
           cfg_reset_len_i, cfg_frame_len_i, cfg_acq_period_i, cfg_frame_cnt_i,
    output reset_win_o, frame_pulse_o, acq_start_o, busy_o, done_pulse_o, frame_idx_o
  );
endinterface

// File: rtl/time_manage_multi.sv
// Trigger-started sequencer: reset window, then repeating frames with staggered
// per-channel ADC acquisition-start pulses; continuous or fixed-length burst.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   S_IDLE      | waiting for rising edge of selected trigger
//   S_RESET_WIN | reset_win_o asserted for reset_len clocks
//   S_FRAME     | frame / acquisition counters running
//   S_DONE      | one-clock burst completion, done_pulse_o
module time_manage_multi #(
  parameter int CNT_W      = 24,
  parameter int CH_NUM     = 4,
  parameter int CH_STAGGER = 8,
  parameter int FCNT_W     = 16
) (
  input logic               sys_clk_i,
  input logic               rst_i,
  time_manage_multi_if.slave bus
);

  localparam int DLY_LEN = (CH_NUM - 1) * CH_STAGGER;
  localparam int DLY_W   = (DLY_LEN > 0) ? DLY_LEN : 1;

  typedef enum logic [1:0] {S_IDLE, S_RESET_WIN, S_FRAME, S_DONE} state_t;

  state_t state, state_n;

  logic [1:0]        gpio_ff, vio_ff, sel_ff;
  logic              trig_s, trig_s_d, start;
  logic              mode_l;
  logic [CNT_W-1:0]  frame_m1_l, acq_m1_l;
  logic [FCNT_W-1:0] cnt_m1_l;
  logic [CNT_W-1:0]  rst_rem, frame_rem, acq_rem;
  logic [FCNT_W-1:0] frame_idx;
  logic [DLY_W-1:0]  dly;
  logic [CH_NUM-1:0] tap, acq_q;
  logic              frame_tc, acq_tc, fpulse, base, abort_now;
  logic              reset_win_q, busy_q, frame_pulse_q, done_q;

  // Zero-length configuration behaves as length one; store terminal counts.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  assign start    = trig_s & ~trig_s_d;
  assign frame_tc = (frame_rem == '0);
  assign acq_tc   = (acq_rem == '0);

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_ff  <= '0;
      vio_ff   <= '0;
      sel_ff   <= '0;
      trig_s   <= 1'b0;
      trig_s_d <= 1'b0;
    end else begin
      gpio_ff  <= {gpio_ff[0], bus.trig_gpio_i};
      vio_ff   <= {vio_ff[0], bus.trig_vio_i};
      sel_ff   <= {sel_ff[0], bus.trig_sel_i};
      trig_s   <= sel_ff[1] ? vio_ff[1] : gpio_ff[1];
      trig_s_d <= trig_s;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fpulse    = 1'b0;
    base      = 1'b0;
    abort_now = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_RESET_WIN;
      S_RESET_WIN: begin
        if (!trig_s) begin
          abort_now = 1'b1;
          state_n   = S_IDLE;
        end else if (rst_rem == '0) begin
          state_n = S_FRAME;
        end
      end
      S_FRAME: begin
        if (!trig_s) begin
          abort_now = 1'b1;
          state_n   = S_IDLE;
        end else begin
          fpulse = frame_tc;
          // frame wrap restarts the acquisition period; a coincident terminal
          // count only fires when both periods are configured identically
          base   = acq_tc && (!frame_tc || (frame_m1_l == acq_m1_l));
          if (frame_tc && mode_l && (frame_idx == cnt_m1_l)) state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_tap
    if (k * CH_STAGGER == 0) begin : g_direct
      assign tap[k] = base;
    end else begin : g_delayed
      assign tap[k] = dly[k*CH_STAGGER-1];
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_l        <= 1'b0;
      frame_m1_l    <= '0;
      acq_m1_l      <= '0;
      cnt_m1_l      <= '0;
      rst_rem       <= '0;
      frame_rem     <= '0;
      acq_rem       <= '0;
      frame_idx     <= '0;
      dly           <= '0;
      acq_q         <= '0;
      reset_win_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_pulse_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_l     <= bus.cfg_mode_i;
            frame_m1_l <= len_m1(bus.cfg_frame_len_i);
            acq_m1_l   <= len_m1(bus.cfg_acq_period_i);
            cnt_m1_l   <= (bus.cfg_frame_cnt_i == '0) ? '0 : bus.cfg_frame_cnt_i - FCNT_W'(1);
            rst_rem    <= len_m1(bus.cfg_reset_len_i);
            frame_idx  <= '0;
          end
        end
        S_RESET_WIN: begin
          if (rst_rem != '0) rst_rem <= rst_rem - CNT_W'(1);
          frame_rem <= frame_m1_l;
          acq_rem   <= acq_m1_l;
        end
        S_FRAME: begin
          if (frame_tc) begin
            frame_rem <= frame_m1_l;
            acq_rem   <= acq_m1_l;
          end else begin
            frame_rem <= frame_rem - CNT_W'(1);
            acq_rem   <= acq_tc ? acq_m1_l : acq_rem - CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (fpulse && (frame_idx != '1)) frame_idx <= frame_idx + FCNT_W'(1);
      dly           <= abort_now ? '0 : ((dly << 1) | DLY_W'(base));
      acq_q         <= abort_now ? '0 : tap;
      reset_win_q   <= (state == S_RESET_WIN) && trig_s;
      busy_q        <= (state != S_IDLE) && !abort_now;
      frame_pulse_q <= fpulse;
      done_q        <= (state == S_DONE);
    end
  end

  assign bus.reset_win_o   = reset_win_q;
  assign bus.busy_o        = busy_q;
  assign bus.frame_pulse_o = frame_pulse_q;
  assign bus.done_pulse_o  = done_q;
  assign bus.acq_start_o   = acq_q;
  assign bus.frame_idx_o   = frame_idx;

endmodule

// File: tb/tb_time_manage_multi.sv
// Scoreboard bench for time_manage_multi: a cycle-indexed reference model
// predicts every output event; a monitor pops and compares as events appear.
module tb_time_manage_multi;
  localparam int CNT_W      = 24;
  localparam int CH_NUM     = 4;
  localparam int CH_STAGGER = 8;
  localparam int FCNT_W     = 4;
  localparam int IDX_MAX    = (1 << FCNT_W) - 1;
  localparam int NEVER      = 32'h3fffffff;

  logic sys_clk_i = 1'b0;
  logic rst_i     = 1'b1;
  always #5 sys_clk_i = ~sys_clk_i;

  time_manage_multi_if #(.CNT_W(CNT_W), .CH_NUM(CH_NUM), .FCNT_W(FCNT_W)) bus ();

  time_manage_multi #(
    .CNT_W(CNT_W), .CH_NUM(CH_NUM), .CH_STAGGER(CH_STAGGER), .FCNT_W(FCNT_W)
  ) dut (
    .sys_clk_i(sys_clk_i),
    .rst_i    (rst_i),
    .bus      (bus)
  );

  typedef struct {
    int                cyc;
    logic              rw;
    logic              busy;
    logic              fp;
    logic [CH_NUM-1:0] acq;
    logic              dp;
    int                idx;
  } ev_t;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic pin = 1'b0, sel = 1'b0, noise = 1'b0, noise_en = 1'b0;

  assign bus.trig_gpio_i = sel ? noise : pin;
  assign bus.trig_vio_i  = sel ? pin : noise;
  assign bus.trig_sel_i  = sel;

  always @(posedge sys_clk_i) cyc <= cyc + 1;
  always @(negedge sys_clk_i) noise <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // frame position of output cycle c, or -1 outside the frame phase
  function automatic int fpos(input int c, input int f0, input int last_f, input int cut, input int fl);
    if (c < f0 || c > last_f || c >= cut) return -1;
    return (c - f0) % fl;
  endfunction

  function automatic bit is_base(input int p, input int fl, input int al);
    return (p >= 0) && ((p % al) == al - 1) && ((p != fl - 1) || (al == fl));
  endfunction

  task automatic push_seq(input int t0, input bit mode, input int rl, input int fl,
                          input int al, input int nl, input int cut, input bit cut_rst);
    int f0, last_f, done_c, end_c, nf, p;
    bit prw, pbusy;
    ev_t e;
    f0 = t0 + rl;
    if (mode) begin
      last_f = f0 + nl * fl - 1;
      done_c = last_f + 1;
      end_c  = done_c + 1 + (CH_NUM - 1) * CH_STAGGER;
    end else begin
      last_f = NEVER;
      done_c = NEVER;
      end_c  = cut;
    end
    if (end_c > cut) end_c = cut;
    nf = 0; prw = 0; pbusy = 0;
    for (int c = t0; c <= end_c; c++) begin
      e.cyc  = c;
      e.rw   = (c < f0) && (c < cut);
      e.busy = (c < cut) && (c <= done_c);
      p      = fpos(c, f0, last_f, cut, fl);
      e.fp   = (p >= 0) && (p == fl - 1);
      if (e.fp) nf++;
      e.dp   = (c == done_c) && (c < cut);
      for (int k = 0; k < CH_NUM; k++)
        e.acq[k] = (c < cut) && is_base(fpos(c - k * CH_STAGGER, f0, last_f, cut, fl), fl, al);
      e.idx  = (cut_rst && c >= cut) ? 0 : ((nf > IDX_MAX) ? IDX_MAX : nf);
      if (e.rw != prw || e.busy != pbusy || e.fp || e.acq != '0 || e.dp) exp_q.push_back(e);
      prw   = e.rw;
      pbusy = e.busy;
    end
  endtask

  initial begin : monitor
    ev_t  m;
    logic prev_rw, prev_busy;
    prev_rw = 1'b0; prev_busy = 1'b0;
    forever begin
      @(posedge sys_clk_i);
      #1;
      if (bus.reset_win_o != prev_rw || bus.busy_o != prev_busy || bus.frame_pulse_o ||
          bus.acq_start_o != '0 || bus.done_pulse_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d rw=%b busy=%b fp=%b acq=%b dp=%b idx=%0d",
                   cyc, bus.reset_win_o, bus.busy_o, bus.frame_pulse_o, bus.acq_start_o,
                   bus.done_pulse_o, bus.frame_idx_o);
        end else begin
          m = exp_q.pop_front();
          if (m.cyc != cyc || m.rw != bus.reset_win_o || m.busy != bus.busy_o ||
              m.fp != bus.frame_pulse_o || m.acq != bus.acq_start_o ||
              m.dp != bus.done_pulse_o || m.idx != int'(bus.frame_idx_o)) begin
            errors++;
            $display("FAIL event got cyc=%0d rw=%b busy=%b fp=%b acq=%b dp=%b idx=%0d expected cyc=%0d rw=%b busy=%b fp=%b acq=%b dp=%b idx=%0d",
                     cyc, bus.reset_win_o, bus.busy_o, bus.frame_pulse_o, bus.acq_start_o,
                     bus.done_pulse_o, bus.frame_idx_o,
                     m.cyc, m.rw, m.busy, m.fp, m.acq, m.dp, m.idx);
          end
        end
      end
      prev_rw   = bus.reset_win_o;
      prev_busy = bus.busy_o;
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (bus.reset_win_o || bus.frame_pulse_o || bus.acq_start_o != '0 || bus.busy_o ||
        bus.done_pulse_o || bus.frame_idx_o != '0) begin
      errors++;
      $display("FAIL %s got rw=%b fp=%b acq=%b busy=%b dp=%b idx=%0d expected all zero",
               name, bus.reset_win_o, bus.frame_pulse_o, bus.acq_start_o, bus.busy_o,
               bus.done_pulse_o, bus.frame_idx_o);
    end
  endtask

  task automatic select_src(input bit s);
    @(negedge sys_clk_i);
    noise_en = 1'b0;
    repeat (4) @(negedge sys_clk_i);
    sel = s;
    repeat (4) @(negedge sys_clk_i);
    noise_en = 1'b1;
  endtask

  task automatic set_cfg(input bit mode, input int r, input int f, input int a, input int n);
    bus.cfg_mode_i       = mode;
    bus.cfg_reset_len_i  = CNT_W'(r);
    bus.cfg_frame_len_i  = CNT_W'(f);
    bus.cfg_acq_period_i = CNT_W'(a);
    bus.cfg_frame_cnt_i  = FCNT_W'(n);
  endtask

  function automatic int one_if_zero(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic run_seq(input bit mode, input int r, input int f, input int a,
                         input int n, input bit s, input int hold);
    int c0, rl, fl, al, nl, cut;
    select_src(s);
    set_cfg(mode, r, f, a, n);
    @(negedge sys_clk_i);
    rl = one_if_zero(r); fl = one_if_zero(f); al = one_if_zero(a); nl = one_if_zero(n);
    pin = 1'b1;
    c0  = cyc;
    cut = mode ? NEVER : c0 + hold + 4;
    push_seq(c0 + 5, mode, rl, fl, al, nl, cut, 1'b0);
    repeat (6) @(negedge sys_clk_i);
    // latched configuration must ignore these
    set_cfg(1'($urandom_range(0, 1)), 20, 20, 3, 1);
    if (mode) begin
      repeat (rl + nl * fl + (CH_NUM - 1) * CH_STAGGER + 12) @(negedge sys_clk_i);
      pin = 1'b0;
      repeat (8) @(negedge sys_clk_i);
    end else begin
      repeat (hold - 6) @(negedge sys_clk_i);
      pin = 1'b0;
      repeat (12) @(negedge sys_clk_i);
    end
  endtask

  task automatic reset_test();
    int c0;
    select_src(1'b0);
    set_cfg(1'b1, 4, 60, 10, 3);
    @(negedge sys_clk_i);
    pin = 1'b1;
    c0  = cyc;
    push_seq(c0 + 5, 1'b1, 4, 60, 10, 3, c0 + 41, 1'b1);
    repeat (40) @(negedge sys_clk_i);
    rst_i = 1'b1;
    pin   = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (3) @(negedge sys_clk_i);
    rst_i = 1'b0;
    repeat (60) @(negedge sys_clk_i);
  endtask

  initial begin : stimulus
    set_cfg(1'b0, 0, 0, 0, 0);
    rst_i = 1'b1;
    repeat (3) @(negedge sys_clk_i);
    check_zero("reset_state");
    rst_i = 1'b0;
    repeat (5) @(negedge sys_clk_i);
    check_zero("post_reset_idle");

    run_seq(1'b1, 10, 100, 30, 3, 1'b0, 0);
    run_seq(1'b0, 5, 50, 50, 0, 1'b0, 400);
    run_seq(1'b1, 0, 0, 0, 0, 1'b0, 0);

    select_src(1'b1);
    repeat (40) @(negedge sys_clk_i);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL sel_ignores_gpio got busy=%b expected 0", bus.busy_o);
    end
    run_seq(1'b1, 3, 20, 7, 2, 1'b1, 0);

    run_seq(1'b0, 2, 1, 1, 0, 1'b1, 40);
    run_seq(1'b0, 9, 12, 5, 0, 1'b0, 8);
    reset_test();
    run_seq(1'b1, 6, 100, 40, 2, 1'b0, 0);
    run_seq(1'b1, 1, 12, 4, 2, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 40),
              $urandom_range(0, 40), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
              $urandom_range(7, 200));
    end

    repeat (30) @(negedge sys_clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending expected 0 (next at cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
